// File: rtl/sync_fifo_prog_pkg.sv
// Shared definitions for the single-clock programmable FIFO.
package sync_fifo_prog_pkg;

    // Read-port behaviour selected at elaboration time.
    typedef enum logic {
        RD_STD  = 1'b0,
        RD_FWFT = 1'b1
    } rd_mode_e;

endpackage

// File: rtl/sync_fifo_prog_mem.sv
// FIFO storage: 1W1R register array, synchronous write, asynchronous read.
module sync_fifo_prog_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    // Store accepted write data; the array has no reset and survives flush.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with standard/FWFT read, run-time almost thresholds,
// synchronous flush and sticky overflow/underflow flags.
module sync_fifo_prog
    import sync_fifo_prog_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int            PW    = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam rd_mode_e      MODE  = (FWFT != 0) ? RD_FWFT : RD_STD;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         cnt_nxt;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ov_set;
    logic                  un_set;

    // Flags come from the registered count, so a same-cycle opposite access
    // never unblocks a full write or an empty read. Flush drops both.
    assign wr_acc = wr_en & ~full  & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;
    assign ov_set = wr_en & full   & ~flush;
    assign un_set = rd_en & empty  & ~flush;

    // Next occupancy: flush empties, simultaneous accept leaves count unchanged.
    always_comb begin
        cnt_nxt = count;
        if (flush) begin
            cnt_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            cnt_nxt = count + PW'(1);
        end else if (rd_acc && !wr_acc) begin
            cnt_nxt = count - PW'(1);
        end
    end

    // Pointers, count and occupancy flags, all registered from the next count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
                if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
            end
            count        <= cnt_nxt;
            full         <= (cnt_nxt == DEPTH);
            empty        <= (cnt_nxt == '0);
            almost_full  <= (cnt_nxt >= af_thresh);
            almost_empty <= (cnt_nxt <= ae_thresh);
        end
    end

    // Sticky error flags; a set in the same cycle as err_clr wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ov_set)       overflow <= 1'b1;
            else if (err_clr) overflow <= 1'b0;
            if (un_set)       underflow <= 1'b1;
            else if (err_clr) underflow <= 1'b0;
        end
    end

    sync_fifo_prog_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    generate
        if (MODE == RD_FWFT) begin : g_fwft
            // Head word is visible whenever the FIFO holds data; zero when empty.
            assign rd_data  = empty ? '0 : mem_rdata;
            assign rd_valid = ~empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_p1;
            logic                  vld_p1;

            // ---- stage p1: registered read data, one-cycle valid pulse ----
            // Capture the head on an accepted read; data holds otherwise.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_p1 <= '0;
                    vld_p1     <= 1'b0;
                end else begin
                    vld_p1 <= rd_acc;
                    if (rd_acc) rd_data_p1 <= mem_rdata;
                end
            end

            assign rd_data  = rd_data_p1;
            assign rd_valid = vld_p1;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog: standard-mode instance driven cycle by
// cycle against a queue model, plus a small FWFT-mode instance.
module tb_sync_fifo_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [4:0] af_thresh;
    logic [4:0] ae_thresh;
    logic       err_clr;

    logic       full, almost_full, rd_valid, empty, almost_empty, overflow, underflow;
    logic [7:0] rd_data;
    logic [4:0] count;

    logic       wr_en1, rd_en1;
    logic       full1, almost_full1, rd_valid1, empty1, almost_empty1, overflow1, underflow1;
    logic [7:0] rd_data1;
    logic [4:0] count1;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];     // model FIFO contents
    logic [7:0] exp_q[$];  // words expected on rd_data
    int         mcount;
    logic       mov, mun;
    logic [7:0] last_rd;

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .empty(empty), .almost_empty(almost_empty), .count(count),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .overflow(overflow),
        .underflow(underflow), .err_clr(err_clr)
    );

    sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en1), .wr_data(wr_data),
        .full(full1), .almost_full(almost_full1), .rd_en(rd_en1), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .empty(empty1), .almost_empty(almost_empty1), .count(count1),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .overflow(overflow1),
        .underflow(underflow1), .err_clr(err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        mcount  = 0;
        mov     = 1'b0;
        mun     = 1'b0;
        last_rd = 8'h00;
    endtask

    // One clock of stimulus on the standard instance, then full output check.
    task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic fl);
        logic       wa, ra, os, us;
        logic [7:0] e;
        wr_en = we; wr_data = wd; rd_en = re; flush = fl;
        wa = we && !fl && (mcount != 16);
        ra = re && !fl && (mcount != 0);
        os = we && !fl && (mcount == 16);
        us = re && !fl && (mcount == 0);
        if (fl) begin
            mq.delete();
        end else begin
            if (ra) exp_q.push_back(mq.pop_front());
            if (wa) mq.push_back(wd);
        end
        mcount = mq.size();
        mov = os ? 1'b1 : (err_clr ? 1'b0 : mov);
        mun = us ? 1'b1 : (err_clr ? 1'b0 : mun);
        @(posedge clk);
        #1;
        chk("count", 32'(count), 32'(mcount));
        chk("full", 32'(full), 32'(mcount == 16));
        chk("empty", 32'(empty), 32'(mcount == 0));
        chk("almost_full", 32'(almost_full), 32'(mcount >= int'(af_thresh)));
        chk("almost_empty", 32'(almost_empty), 32'(mcount <= int'(ae_thresh)));
        chk("overflow", 32'(overflow), 32'(mov));
        chk("underflow", 32'(underflow), 32'(mun));
        chk("rd_valid", 32'(rd_valid), 32'(ra));
        if (rd_valid) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_data", 32'(rd_data), 32'(e));
                last_rd = e;
            end else begin
                chk("sb_depth", 32'(exp_q.size()), 32'd1);
            end
        end else begin
            chk("rd_hold", 32'(rd_data), 32'(last_rd));
        end
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_ae"}, 32'(almost_empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_af"}, 32'(almost_full), 32'd0);
        chk({tag, "_vld"}, 32'(rd_valid), 32'd0);
        chk({tag, "_data"}, 32'(rd_data), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_unf"}, 32'(underflow), 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
        wr_en1 = 1'b0; rd_en1 = 1'b0; err_clr = 1'b0;
        af_thresh = 5'd14; ae_thresh = 5'd2;
        model_reset();
        #12;
        chk_reset_outputs("rst0");
        rst = 1'b0;

        // Fill/drain with thresholds 14/2 checked on every edge.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Full with write+read: write dropped, overflow, count 15.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        err_clr = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        err_clr = 1'b0;
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        // Empty with write+read: read dropped, underflow, count 1.
        step(1'b1, 8'h77, 1'b1, 1'b0);
        err_clr = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        err_clr = 1'b0;

        // Pointer wrap: three rounds of 10 in / 10 out.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h80 + r * 16 + i), 1'b0, 1'b0);
            for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Threshold extremes.
        af_thresh = 5'd0; ae_thresh = 5'd16;
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        af_thresh = 5'd14; ae_thresh = 5'd2;
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Leave a sticky underflow, then flush 5 queued words while writing.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b1, 8'hCF, 1'b0, 1'b1);
        step(1'b1, 8'hD0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a write burst.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
        wr_en = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("rst_mid");
        wr_en = 1'b0;
        model_reset();
        rst = 1'b0;
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // FWFT instance: word falls through without rd_en, pop clears valid.
        chk("fwft_idle_vld", 32'(rd_valid1), 32'd0);
        wr_data = 8'hA5; wr_en1 = 1'b1;
        @(posedge clk); #1;
        wr_en1 = 1'b0;
        chk("fwft_vld", 32'(rd_valid1), 32'd1);
        chk("fwft_data", 32'(rd_data1), 32'hA5);
        @(posedge clk); #1;
        chk("fwft_hold", 32'(rd_data1), 32'hA5);
        rd_en1 = 1'b1;
        @(posedge clk); #1;
        rd_en1 = 1'b0;
        chk("fwft_pop_vld", 32'(rd_valid1), 32'd0);
        chk("fwft_pop_empty", 32'(empty1), 32'd1);
        chk("fwft_unf", 32'(underflow1), 32'd0);

        chk("sb_left", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
